// File: rtl/uv_i2c_slave.sv
// I2C target with a small byte register file: pointer-addressed writes, auto-incrementing reads.
// Define UV_I2C_SLV_FILTER_EN to add a 3-sample glitch filter on SCL/SDA (pad-to-event latency 6 clk instead of 3).
module uv_i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int          REG_NUM  = 16,
    parameter int          REG_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i2c_scl_in,
    output logic                 i2c_scl_out,
    output logic                 i2c_scl_oen,
    input  logic                 i2c_sda_in,
    output logic                 i2c_sda_out,
    output logic                 i2c_sda_oen,
    output logic [REG_NUM*8-1:0] regs_out,
    output logic                 wr_pulse,
    output logic [REG_AW-1:0]    wr_idx,
    output logic                 busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                      state, state_nxt;
    logic [1:0]                  scl_sync, sda_sync;
    logic                        scl_line, sda_line, scl_d, sda_d;
    logic [2:0]                  bit_cnt;
    logic [6:0]                  shift_reg;
    logic                        rw;
    logic [REG_AW-1:0]           ptr;
    logic [REG_NUM-1:0][7:0]     regs;
    logic                        sda_oen_r, sda_oen_nxt;
    logic                        scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0]                  byte_in;

    // Idle bus is high on both lines, so synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl_in};
            sda_sync <= {sda_sync[0], i2c_sda_in};
        end
    end

`ifdef UV_I2C_SLV_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // The filtered level only moves once three consecutive samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_line <= 1'b1;
            sda_line <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if ({scl_hist, scl_sync[1]} == 3'b111)      scl_line <= 1'b1;
            else if ({scl_hist, scl_sync[1]} == 3'b000) scl_line <= 1'b0;
            if ({sda_hist, sda_sync[1]} == 3'b111)      sda_line <= 1'b1;
            else if ({sda_hist, sda_sync[1]} == 3'b000) sda_line <= 1'b0;
        end
    end
`else
    assign scl_line = scl_sync[1];
    assign sda_line = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_line;
            sda_d <= sda_line;
        end
    end

    assign scl_rise  = scl_line & ~scl_d;
    assign scl_fall  = ~scl_line & scl_d;
    assign start_det = scl_line & scl_d & sda_d & ~sda_line;
    assign stop_det  = scl_line & scl_d & ~sda_d & sda_line;
    assign last_bit  = (bit_cnt == 3'd7);
    assign byte_in   = {shift_reg, sda_line};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else if (scl_rise) begin
            case (state)
                ADDR:      if (last_bit) state_nxt = (byte_in[7:1] == SLV_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_nxt = rw ? RDATA : PTR;
                PTR:       if (last_bit) state_nxt = PTR_ACK;
                PTR_ACK:   state_nxt = WDATA;
                WDATA:     if (last_bit) state_nxt = WDATA_ACK;
                WDATA_ACK: state_nxt = WDATA;
                RDATA:     if (last_bit) state_nxt = RDATA_ACK;
                RDATA_ACK: state_nxt = sda_line ? IDLE : RDATA;
                default:   state_nxt = state;
            endcase
        end
    end

    // SDA only changes on SCL fall; bit_cnt equals bits already sent, so ~bit_cnt picks MSB first.
    always_comb begin
        sda_oen_nxt = sda_oen_r;
        if (start_det || stop_det || state == IDLE) begin
            sda_oen_nxt = 1'b1;
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oen_nxt = 1'b0;
                RDATA:                        sda_oen_nxt = regs[ptr][~bit_cnt];
                default:                      sda_oen_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            regs      <= '0;
            sda_oen_r <= 1'b1;
            wr_pulse  <= 1'b0;
            wr_idx    <= '0;
            busy      <= 1'b0;
        end else begin
            sda_oen_r <= sda_oen_nxt;
            wr_pulse  <= 1'b0;
            if (start_det) begin
                bit_cnt <= '0;
            end else if (stop_det) begin
                busy <= 1'b0;
            end else if (scl_rise) begin
                shift_reg <= byte_in[6:0];
                if (state == ADDR_ACK || state == PTR_ACK || state == WDATA_ACK || state == RDATA_ACK)
                    bit_cnt <= '0;
                else
                    bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    ADDR: if (last_bit) begin
                        rw <= sda_line;
                        if (byte_in[7:1] == SLV_ADDR) busy <= 1'b1;
                    end
                    PTR: if (last_bit) ptr <= byte_in[REG_AW-1:0];
                    WDATA: if (last_bit) begin
                        regs[ptr] <= byte_in;
                        wr_pulse  <= 1'b1;
                        wr_idx    <= ptr;
                        ptr       <= ptr + REG_AW'(1);
                    end
                    RDATA_ACK: ptr <= ptr + REG_AW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign i2c_scl_out = 1'b0;
    assign i2c_scl_oen = 1'b1;
    assign i2c_sda_out = 1'b0;
    assign i2c_sda_oen = sda_oen_r;
    assign regs_out    = regs;

endmodule

// File: tb/tb_uv_i2c_slave.sv
// Bench for uv_i2c_slave: a bit-banged open-drain I2C master with randomized transactions
// checked against a register-file/pointer model of the target.
`timescale 1ns/1ps
module tb_uv_i2c_slave;

    localparam int REG_NUM = 16;
    localparam int REG_AW  = 4;
    localparam int Q       = 6;

    typedef logic [7:0] byte_q_t [$];

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 scl_m = 1'b1;
    logic                 sda_m = 1'b1;
    logic                 sda_bus;
    logic                 i2c_scl_out, i2c_scl_oen, i2c_sda_out, i2c_sda_oen;
    logic [REG_NUM*8-1:0] regs_out;
    logic                 wr_pulse;
    logic [REG_AW-1:0]    wr_idx;
    logic                 busy;

    int                   check_count = 0;
    int                   error_count = 0;
    logic [7:0]           model_regs [REG_NUM];
    int                   model_ptr = 0;
    int                   exp_idx [$];
    int                   got_idx [$];

    assign sda_bus = sda_m & (i2c_sda_oen | i2c_sda_out);

    always #5 clk = ~clk;

    uv_i2c_slave #(.SLV_ADDR(7'h50), .REG_NUM(REG_NUM), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_scl_in(scl_m), .i2c_scl_out(i2c_scl_out), .i2c_scl_oen(i2c_scl_oen),
        .i2c_sda_in(sda_bus), .i2c_sda_out(i2c_sda_out), .i2c_sda_oen(i2c_sda_oen),
        .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_idx(wr_idx), .busy(busy)
    );

    always @(negedge clk) if (rst_n && wr_pulse) got_idx.push_back(int'(wr_idx));

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;  wait_q();
        scl_m = 1'b1; wait_q();
        s = sda_bus; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(nack, s);
    endtask

    task automatic check_regs(input string tag);
        logic [127:0] exp;
        for (int i = 0; i < REG_NUM; i++) exp[i*8 +: 8] = model_regs[i];
        checkOutput(tag, regs_out, exp);
    endtask

    task automatic check_writes();
        checkOutput("wr_count", got_idx.size(), exp_idx.size());
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++)
            checkOutput("wr_idx", got_idx[i], exp_idx[i]);
        got_idx.delete();
        exp_idx.delete();
    endtask

    task automatic master_write(input logic [7:0] ptr_byte, input byte_q_t data);
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);      checkOutput("wr_addr_ack", ack, 1'b0);
        checkOutput("busy_set", busy, 1'b1);
        send_byte(ptr_byte, ack);   checkOutput("ptr_ack", ack, 1'b0);
        model_ptr = ptr_byte % REG_NUM;
        foreach (data[i]) begin
            send_byte(data[i], ack); checkOutput("data_ack", ack, 1'b0);
            model_regs[model_ptr] = data[i];
            exp_idx.push_back(model_ptr);
            model_ptr = (model_ptr + 1) % REG_NUM;
        end
        bus_stop();
        repeat (4) @(negedge clk);
        checkOutput("busy_clr", busy, 1'b0);
        check_regs("regs_after_wr");
        check_writes();
    endtask

    task automatic master_read(input bit set_ptr, input logic [7:0] ptr_byte, input int count);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, ack);    checkOutput("rd_waddr_ack", ack, 1'b0);
            send_byte(ptr_byte, ack); checkOutput("rd_ptr_ack", ack, 1'b0);
            model_ptr = ptr_byte % REG_NUM;
            bus_start();
        end
        send_byte(8'hA1, ack);        checkOutput("rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < count; i++) begin
            recv_byte(d, (i == count - 1));
            checkOutput("rdata", d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % REG_NUM;
        end
        repeat (2) @(negedge clk);
        checkOutput("oen_after_nack", i2c_sda_oen, 1'b1);
        checkOutput("busy_after_nack", busy, 1'b1);
        bus_stop();
        repeat (4) @(negedge clk);
        checkOutput("busy_clr_rd", busy, 1'b0);
        check_writes();
    endtask

    task automatic bad_address(input logic [6:0] addr);
        logic ack;
        bus_start();
        send_byte({addr, 1'b0}, ack); checkOutput("bad_addr_nack", ack, 1'b1);
        checkOutput("bad_addr_busy", busy, 1'b0);
        send_byte(8'($urandom), ack); checkOutput("ignored_nack", ack, 1'b1);
        bus_stop();
        repeat (4) @(negedge clk);
        check_regs("regs_after_bad");
        check_writes();
    endtask

    task automatic applyStimulus();
        byte_q_t    data;
        logic [6:0] addr;
        case ($urandom_range(0, 3))
            0: begin
                data.delete();
                repeat ($urandom_range(0, 4)) data.push_back(8'($urandom));
                master_write(8'($urandom), data);
            end
            1: master_read(1'b1, 8'($urandom), $urandom_range(1, 4));
            2: master_read(1'b0, 8'h00, $urandom_range(1, 3));
            default: begin
                addr = 7'($urandom);
                if (addr == 7'h50) addr = 7'h51;
                bad_address(addr);
            end
        endcase
    endtask

    initial begin
        byte_q_t data;
        logic    ack, s;
        foreach (model_regs[i]) model_regs[i] = 8'h00;

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_oen", i2c_sda_oen, 1'b1);
        checkOutput("rst_regs", regs_out, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_pulse", wr_pulse, 1'b0);
        checkOutput("scl_oen", i2c_scl_oen, 1'b1);

        data = '{8'h11, 8'h22};
        master_write(8'h03, data);
        checkOutput("reg3", regs_out[31:24], 8'h11);
        checkOutput("reg4", regs_out[39:32], 8'h22);

        data = '{8'h5A, 8'hC3};
        master_write(8'h0F, data);
        checkOutput("reg15_wrap", regs_out[127:120], 8'h5A);
        checkOutput("reg0_wrap", regs_out[7:0], 8'hC3);

        master_read(1'b1, 8'h02, 3);
        master_read(1'b0, 8'h00, 1);
        bad_address(7'h51);

        for (int n = 0; n < 18; n++) applyStimulus();

        // Mid-read reset: target must let go of SDA at once and forget everything.
        bus_start();
        send_byte(8'hA1, ack);
        checkOutput("pre_rst_ack", ack, 1'b0);
        repeat (3) clock_bit(1'b1, s);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_oen", i2c_sda_oen, 1'b1);
        checkOutput("midrst_regs", regs_out, '0);
        checkOutput("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        foreach (model_regs[i]) model_regs[i] = 8'h00;
        model_ptr = 0;
        got_idx.delete();
        exp_idx.delete();
        bus_stop();
        repeat (4) @(negedge clk);
        data = '{8'hE7, 8'h3C, 8'h81};
        master_write(8'h07, data);
        master_read(1'b1, 8'h06, 4);

        // A 2-clk SDA dip with SCL high looks like START+STOP only without the filter.
        bus_start();
        send_byte(8'hA0, ack);
        checkOutput("glitch_addr_ack", ack, 1'b0);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; repeat (2) @(negedge clk);
        sda_m = 1'b1; wait_q();
`ifdef UV_I2C_SLV_FILTER_EN
        checkOutput("glitch_busy", busy, 1'b1);
`else
        checkOutput("glitch_busy", busy, 1'b0);
`endif
        scl_m = 1'b0; wait_q();
        bus_stop();
        repeat (4) @(negedge clk);
        check_regs("regs_after_glitch");
        check_writes();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/uv_i2c_slave.md
Name: uv_i2c_slave

Overview:
- I2C target (responder): the other end of the SoC I2C master bus, for bench loopback and for board-level peripheral emulation.
- Holds a small byte register file. Supports pointer-addressed writes and auto-incrementing reads.
- Connects to open-drain pad signals of the same form as the IOB I2C pins: in / out / oen.
- Runs on a single system clock and oversamples SCL/SDA.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address matched against the address byte.
- REG_NUM, 16, number of 8-bit registers; power of two, 2..256.
- REG_AW, 4, register pointer width; must equal log2(REG_NUM).

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- i2c_scl_in  input  1  SCL pad input.
- i2c_scl_out  output  1  SCL output level; constant 0.
- i2c_scl_oen  output  1  SCL output enable, active low; constant 1 (no clock stretching).
- i2c_sda_in  input  1  SDA pad input.
- i2c_sda_out  output  1  SDA output level; constant 0 (open drain).
- i2c_sda_oen  output  1  SDA output enable, active low; 0 pulls SDA low.
- regs_out  output  REG_NUM*8  flattened register file; reg[i] is at bits [8i+7:8i].
- wr_pulse  output  1  one-cycle pulse after each data byte is written.
- wr_idx  output  REG_AW  index written; valid while wr_pulse=1.
- busy  output  1  high from an address-matched START until STOP or abort.

Behaviour:
- Reset values: sda_oen=1, all regs=0, pointer=0, wr_pulse=0, wr_idx=0, busy=0, FSM=IDLE.
- Input path:
  - SCL and SDA each pass through a 2-flop synchronizer, then a 1-flop delayed copy used for edge detection.
  - Pad-to-event latency is 3 clk.
- Bus events:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - SCL rise: sample SDA.
  - SCL fall: update the SDA drive.
- Bit counter: 3 bits, cleared on START and after every ACK slot.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state, including a repeated START: goes to ADDR, releases SDA, clears the bit counter. The pointer is kept.
- STOP from any state: goes to IDLE, releases SDA, busy=0.
- ADDR:
  - Shift in 8 bits, MSB first.
  - If bits[7:1]==SLV_ADDR: go to ADDR_ACK and set busy=1.
  - Otherwise: go to IDLE and ignore the bus until the next START.
- ACK slots (ADDR_ACK, PTR_ACK, WDATA_ACK): drive SDA low on the SCL fall after the 8th bit; release it on the next SCL fall.
- After ADDR_ACK:
  - R/W=0 goes to PTR.
  - R/W=1 goes to RDATA. reg[ptr] bit 7 is driven on the same SCL fall that ends the ACK.
- PTR: the first written byte loads the pointer (low REG_AW bits; upper bits ignored), then PTR_ACK, then WDATA.
- WDATA:
  - Each byte writes reg[ptr], then ACK.
  - wr_pulse and wr_idx=ptr fire on the cycle after the 8th-bit sample.
  - ptr increments modulo REG_NUM, so REG_NUM-1 wraps to 0.
- RDATA:
  - Shifts out reg[ptr] MSB first, one bit per SCL fall.
  - A bit value of 1 is sent by releasing SDA.
  - After the 8th bit, SDA is released for RDATA_ACK.
- RDATA_ACK:
  - The master's ACK is sampled on SCL rise.
  - ACK (0): ptr++ with wrap, then RDATA with the next byte.
  - NACK (1): ptr++ with wrap, then IDLE with SDA released; busy stays 1 until STOP.
- SDA is never driven while in IDLE.
- A read transfers are never stalled.
- Reset asserted mid-transfer: outputs return to their reset values immediately and SDA is released. Traffic is then ignored until the next START.
- Simultaneous START and data edge in the same cycle: START takes priority.

Optional Feature:
- Macro: UV_I2C_SLV_FILTER_EN.
- Defined:
  - After the synchronizers, each line goes through a 3-sample shift register.
  - The filtered value changes only when all 3 samples agree, suppressing glitches shorter than 3 clk.
  - Pad-to-event latency becomes 6 clk.
- Undefined: no filter; latency is 3 clk.

Test Plan:
- Write 0xA0, 0x03, 0x11, 0x22, STOP -> ACK on all bytes; reg[3]=0x11, reg[4]=0x22; wr_pulse twice with wr_idx 3 then 4; busy=0 after STOP.
- Write 0xA0, 0x0F, 0x5A, 0xC3 (REG_NUM=16) -> reg[15]=0x5A, reg[0]=0xC3; ptr wraps.
- Write 0xA0, 0x02, repeated START, 0xA1, master ACK, ACK, NACK, STOP -> returns reg[2], reg[3], reg[4]; ptr ends at 5; sda_oen=1 after NACK.
- Address 0xA2 (7'h51) -> no ACK (SDA high at the 9th clock); no reg change; busy stays 0.
- Reset pulse mid-byte of a read -> sda_oen=1 within one clk of reset assertion; regs=0; next full transaction completes correctly.
- With UV_I2C_SLV_FILTER_EN: 2-clk low glitch on SDA while SCL=1 -> no START/STOP detected; the same glitch without the macro -> false START detected.
